// File: rtl/address_generation_unit.sv
// Address generation unit: holds the memory address and drives it onto the bus,
// with load, strided single steps, optional window wrap and fixed-length bursts.
module address_generation_unit #(
    parameter int ADDR_WIDTH   = 16,
    parameter int STRIDE_WIDTH = 8,
    parameter int LEN_WIDTH    = 8
) (
    input  logic                    AGU_clk,
    input  logic                    AGU_rst_n,
    input  logic [ADDR_WIDTH-1:0]   AGU_in,
    input  logic                    AGU_wr_en,
    input  logic                    AGU_inc_en,
    input  logic                    AGU_dec_en,
    input  logic [STRIDE_WIDTH-1:0] AGU_stride_in,
    input  logic                    AGU_stride_wr_en,
    input  logic [ADDR_WIDTH-1:0]   AGU_lim_lo_in,
    input  logic [ADDR_WIDTH-1:0]   AGU_lim_hi_in,
    input  logic                    AGU_lim_wr_en,
    input  logic                    AGU_wrap_en,
    input  logic                    AGU_burst_start,
    input  logic [LEN_WIDTH-1:0]    AGU_burst_len,
    output logic [ADDR_WIDTH-1:0]   AGU_out,
    output logic                    AGU_busy,
    output logic                    AGU_done,
    output logic                    AGU_wrapped
);

    localparam int SPAD = ADDR_WIDTH + 1 - STRIDE_WIDTH;

    typedef enum logic {S_IDLE, S_BURST} state_t;

    state_t                  r_state, w_state_nxt;
    logic [LEN_WIDTH-1:0]    r_count, w_count_nxt;
    logic [ADDR_WIDTH-1:0]   r_addr, w_addr_nxt;
    logic                    r_done, w_done_nxt;
    logic                    r_wrapped, w_wrapped_nxt;
    logic [STRIDE_WIDTH-1:0] r_stride;
    logic [ADDR_WIDTH-1:0]   r_lim_lo, r_lim_hi;

    // All step arithmetic is one bit wider so carry/borrow and window compares are exact.
    logic [ADDR_WIDTH:0]     w_stride_ext, w_sum, w_diff, w_lo_plus;
    logic [ADDR_WIDTH-1:0]   w_inc_addr, w_dec_addr;
    logic                    w_inc_wrap, w_dec_wrap;

    assign w_stride_ext = {{SPAD{1'b0}}, r_stride};
    assign w_sum        = {1'b0, r_addr} + w_stride_ext;
    assign w_diff       = {1'b0, r_addr} - w_stride_ext;
    assign w_lo_plus    = {1'b0, r_lim_lo} + w_stride_ext;

    always_comb begin
        if (AGU_wrap_en) begin
            w_inc_wrap = (w_sum > {1'b0, r_lim_hi});
            w_inc_addr = w_inc_wrap ? r_lim_lo : w_sum[ADDR_WIDTH-1:0];
            w_dec_wrap = ({1'b0, r_addr} < w_lo_plus);
            w_dec_addr = w_dec_wrap ? r_lim_hi : w_diff[ADDR_WIDTH-1:0];
        end else begin
            w_inc_wrap = w_sum[ADDR_WIDTH];
            w_inc_addr = w_sum[ADDR_WIDTH-1:0];
            w_dec_wrap = w_diff[ADDR_WIDTH];
            w_dec_addr = w_diff[ADDR_WIDTH-1:0];
        end
    end

    // A load overrides everything, including aborting a running burst without done.
    always_comb begin
        w_state_nxt   = r_state;
        w_count_nxt   = r_count;
        w_addr_nxt    = r_addr;
        w_done_nxt    = 1'b0;
        w_wrapped_nxt = 1'b0;
        if (AGU_wr_en) begin
            w_addr_nxt  = AGU_in;
            w_state_nxt = S_IDLE;
            w_count_nxt = '0;
        end else begin
            case (r_state)
                S_BURST: begin
                    w_addr_nxt    = w_inc_addr;
                    w_wrapped_nxt = w_inc_wrap;
                    w_count_nxt   = r_count - LEN_WIDTH'(1);
                    if (r_count == LEN_WIDTH'(1)) begin
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
                default: begin
                    if (AGU_burst_start) begin
                        if (AGU_burst_len == '0) begin
                            w_done_nxt = 1'b1;
                        end else begin
                            w_count_nxt = AGU_burst_len;
                            w_state_nxt = S_BURST;
                        end
                    end else if (AGU_inc_en && !AGU_dec_en) begin
                        w_addr_nxt    = w_inc_addr;
                        w_wrapped_nxt = w_inc_wrap;
                    end else if (AGU_dec_en && !AGU_inc_en) begin
                        w_addr_nxt    = w_dec_addr;
                        w_wrapped_nxt = w_dec_wrap;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge AGU_clk or negedge AGU_rst_n) begin
        if (!AGU_rst_n) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_addr    <= '0;
            r_done    <= 1'b0;
            r_wrapped <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_count   <= w_count_nxt;
            r_addr    <= w_addr_nxt;
            r_done    <= w_done_nxt;
            r_wrapped <= w_wrapped_nxt;
        end
    end

    // Configuration only changes while idle; an inverted window is rejected whole.
    always_ff @(posedge AGU_clk or negedge AGU_rst_n) begin
        if (!AGU_rst_n) begin
            r_stride <= STRIDE_WIDTH'(1);
            r_lim_lo <= '0;
            r_lim_hi <= '1;
        end else if (r_state == S_IDLE) begin
            if (AGU_stride_wr_en)
                r_stride <= AGU_stride_in;
            if (AGU_lim_wr_en && (AGU_lim_lo_in <= AGU_lim_hi_in)) begin
                r_lim_lo <= AGU_lim_lo_in;
                r_lim_hi <= AGU_lim_hi_in;
            end
        end
    end

    assign AGU_out     = r_addr;
    assign AGU_busy    = (r_state == S_BURST);
    assign AGU_done    = r_done;
    assign AGU_wrapped = r_wrapped;

endmodule

// File: tb/tb_address_generation_unit.sv
// Self-checking bench for address_generation_unit: directed steps, then random traffic
// compared cycle by cycle against an integer reference model.
module tb_address_generation_unit;

    localparam int AW   = 16;
    localparam int SW   = 8;
    localparam int LW   = 8;
    localparam int AMOD = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] AGU_in = '0;
    logic          wr_en = 1'b0, inc_en = 1'b0, dec_en = 1'b0;
    logic [SW-1:0] stride_in = '0;
    logic          stride_wr = 1'b0;
    logic [AW-1:0] lim_lo = '0, lim_hi = '0;
    logic          lim_wr = 1'b0, wrap_en = 1'b0, burst_start = 1'b0;
    logic [LW-1:0] burst_len = '0;
    logic [AW-1:0] out;
    logic          busy, done, wrapped;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state in plain integers.
    int m_addr, m_stride, m_lo, m_hi, m_rem;
    bit m_done, m_wrapped;

    address_generation_unit #(.ADDR_WIDTH(AW), .STRIDE_WIDTH(SW), .LEN_WIDTH(LW)) dut (
        .AGU_clk(clk), .AGU_rst_n(rst_n), .AGU_in(AGU_in), .AGU_wr_en(wr_en),
        .AGU_inc_en(inc_en), .AGU_dec_en(dec_en), .AGU_stride_in(stride_in),
        .AGU_stride_wr_en(stride_wr), .AGU_lim_lo_in(lim_lo), .AGU_lim_hi_in(lim_hi),
        .AGU_lim_wr_en(lim_wr), .AGU_wrap_en(wrap_en), .AGU_burst_start(burst_start),
        .AGU_burst_len(burst_len), .AGU_out(out), .AGU_busy(busy), .AGU_done(done),
        .AGU_wrapped(wrapped)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_addr = 0; m_stride = 1; m_lo = 0; m_hi = AMOD - 1;
        m_rem = 0; m_done = 0; m_wrapped = 0;
    endtask

    task automatic step_up(inout bit nw);
        int s;
        s = m_addr + m_stride;
        if (wrap_en) begin
            if (s > m_hi) begin m_addr = m_lo; nw = 1; end
            else m_addr = s;
        end else begin
            if (s >= AMOD) begin m_addr = s - AMOD; nw = 1; end
            else m_addr = s;
        end
    endtask

    task automatic step_down(inout bit nw);
        if (wrap_en) begin
            if (m_addr < m_lo + m_stride) begin m_addr = m_hi; nw = 1; end
            else m_addr = m_addr - m_stride;
        end else begin
            if (m_addr < m_stride) begin m_addr = m_addr - m_stride + AMOD; nw = 1; end
            else m_addr = m_addr - m_stride;
        end
    endtask

    // Applies the block's rules for one clock edge to the integer model.
    task automatic model_edge();
        bit nd, nw, idle;
        nd = 0; nw = 0;
        idle = (m_rem == 0);
        if (wr_en) begin
            m_addr = int'(AGU_in);
            m_rem  = 0;
        end else if (!idle) begin
            step_up(nw);
            m_rem--;
            if (m_rem == 0) nd = 1;
        end else if (burst_start) begin
            if (burst_len == 0) nd = 1;
            else m_rem = int'(burst_len);
        end else if (inc_en && !dec_en) begin
            step_up(nw);
        end else if (dec_en && !inc_en) begin
            step_down(nw);
        end
        if (idle) begin
            if (stride_wr) m_stride = int'(stride_in);
            if (lim_wr && lim_lo <= lim_hi) begin
                m_lo = int'(lim_lo);
                m_hi = int'(lim_hi);
            end
        end
        m_done = nd;
        m_wrapped = nw;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".out"}, 32'(out), m_addr);
        chk({tag, ".busy"}, 32'(busy), (m_rem != 0) ? 1 : 0);
        chk({tag, ".done"}, 32'(done), 32'(m_done));
        chk({tag, ".wrapped"}, 32'(wrapped), 32'(m_wrapped));
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic clr();
        wr_en = 0; inc_en = 0; dec_en = 0; stride_wr = 0; lim_wr = 0; burst_start = 0;
    endtask

    initial begin
        // Reset values, checked before any clock edge.
        model_reset();
        #2;
        check_all("reset");
        chk("reset.out_const", 32'(out), 0);
        #10 rst_n = 1;                        // release between edges (t=12)

        // Mid-burst asynchronous reset, then a load.
        burst_len = 8; burst_start = 1;
        tick("rst_burst_start");
        clr();
        tick("rst_burst1");
        tick("rst_burst2");
        chk("rst_pre_busy", 32'(busy), 1);
        #2 rst_n = 0;
        #1;
        model_reset();
        check_all("async_rst");
        chk("async_rst.busy0", 32'(busy), 0);
        @(posedge clk);
        #1 rst_n = 1;
        AGU_in = 16'h1234; wr_en = 1;
        tick("load");
        clr();
        chk("load.const", 32'(out), 32'h1234);

        // Modulo wrap with stride 1.
        AGU_in = 16'hFFFF; wr_en = 1;
        tick("mod_load");
        clr(); inc_en = 1;
        tick("mod_inc");
        chk("mod_inc.const", 32'(out), 0);
        chk("mod_inc.wrapped", 32'(wrapped), 1);
        clr();
        tick("mod_idle");
        chk("mod_idle.wrapped0", 32'(wrapped), 0);
        dec_en = 1;
        tick("mod_dec");
        chk("mod_dec.const", 32'(out), 32'hFFFF);
        chk("mod_dec.wrapped", 32'(wrapped), 1);

        // Window wrap.
        clr();
        lim_lo = 16'h0100; lim_hi = 16'h010F; lim_wr = 1;
        stride_in = 4; stride_wr = 1;
        AGU_in = 16'h010C; wr_en = 1;
        tick("win_cfg");
        clr(); wrap_en = 1; inc_en = 1;
        tick("win_inc");
        chk("win_inc.const", 32'(out), 32'h0100);
        clr(); dec_en = 1;
        tick("win_dec");
        chk("win_dec.const", 32'(out), 32'h010F);
        clr(); lim_lo = 16'h0020; lim_hi = 16'h0010; lim_wr = 1;
        tick("win_badlim");
        clr(); inc_en = 1;
        tick("win_inc2");
        chk("win_badlim_kept", 32'(out), 32'h0100);

        // Burst of 4, stride 2.
        clr(); wrap_en = 0;
        stride_in = 2; stride_wr = 1; AGU_in = 16'h0100; wr_en = 1;
        tick("burst_cfg");
        clr(); burst_len = 4; burst_start = 1;
        tick("burst_k0");
        clr();
        chk("burst_k0.const", 32'(out), 32'h0100);
        for (int k = 1; k < 4; k++) begin
            tick("burst_k");
            chk("burst_k.const", 32'(out), 32'h0100 + 2 * k);
            chk("burst_k.busy", 32'(busy), 1);
        end
        tick("burst_end");
        chk("burst_end.out", 32'(out), 32'h0108);
        chk("burst_end.done", 32'(done), 1);
        chk("burst_end.busy", 32'(busy), 0);

        // Abort by load on the second burst cycle.
        burst_len = 4; burst_start = 1;
        tick("abort_k0");
        clr();
        tick("abort_k1");
        AGU_in = 16'h0500; wr_en = 1;
        tick("abort_load");
        clr();
        chk("abort.out", 32'(out), 32'h0500);
        chk("abort.busy", 32'(busy), 0);
        tick("abort_after");
        chk("abort.nodone", 32'(done), 0);

        // Zero length burst, inc+dec together, stride write while busy.
        burst_len = 0; burst_start = 1;
        tick("len0");
        clr();
        chk("len0.done", 32'(done), 1);
        chk("len0.busy", 32'(busy), 0);
        inc_en = 1; dec_en = 1;
        tick("incdec");
        clr();
        chk("incdec.const", 32'(out), 32'h0500);
        burst_len = 3; burst_start = 1;
        tick("sbusy_start");
        clr(); stride_in = 7; stride_wr = 1;
        tick("sbusy_wr");
        clr();
        tick("sbusy_b2");
        tick("sbusy_done");
        inc_en = 1;
        tick("sbusy_inc");
        clr();
        chk("sbusy.stride_kept", 32'(out), 32'h0508);

        // Randomized traffic against the model.
        for (int i = 0; i < 800; i++) begin
            int r;
            clr();
            r = int'($urandom_range(0, 99));
            AGU_in = AW'($urandom);
            stride_in = ($urandom_range(0, 3) == 0) ? SW'($urandom) : SW'($urandom_range(0, 5));
            burst_len = LW'($urandom_range(0, 6));
            if ($urandom_range(0, 19) == 0) wrap_en = ~wrap_en;
            if (r < 8) wr_en = 1;
            else if (r < 30) inc_en = 1;
            else if (r < 45) dec_en = 1;
            else if (r < 49) begin inc_en = 1; dec_en = 1; end
            else if (r < 57) stride_wr = 1;
            else if (r < 64) begin
                int lo;
                lo = int'($urandom_range(0, AMOD - 1));
                lim_lo = AW'(lo);
                lim_hi = AW'((lo + int'($urandom_range(0, 200))) % AMOD);
                if ($urandom_range(0, 4) == 0) begin lim_lo = lim_hi; lim_hi = AW'(lo); end
                lim_wr = 1;
            end else if (r < 74) burst_start = 1;
            if ($urandom_range(0, 9) == 0) stride_wr = 1;
            if ($urandom_range(0, 9) == 0) burst_start = 1;
            tick("rand");
        end
        clr();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/address_generation_unit.md
# address_generation_unit

Parametrised successor to the memory address register. It holds the current memory address and drives it combinationally onto the address bus. It also generates addresses on its own: load, single step by a programmable stride, optional circular wrap inside a programmable window, and autonomous fixed-length bursts. It sits between the control unit and memory, in place of the plain address register.

## Interface
- ADDR_WIDTH, 16, address width
- STRIDE_WIDTH, 8, stride register width (unsigned, zero-extended)
- LEN_WIDTH, 8, burst length width
- AGU_clk  in  1  sole clock, rising edge
- AGU_rst_n  in  1  asynchronous, active-low reset
- AGU_in  in  ADDR_WIDTH  address load value
- AGU_wr_en  in  1  load AGU_in into address register
- AGU_inc_en  in  1  single step +stride (idle only)
- AGU_dec_en  in  1  single step −stride (idle only)
- AGU_stride_in  in  STRIDE_WIDTH  stride value
- AGU_stride_wr_en  in  1  write stride register
- AGU_lim_lo_in / AGU_lim_hi_in  in  ADDR_WIDTH  window bounds, inclusive
- AGU_lim_wr_en  in  1  write both bounds
- AGU_wrap_en  in  1  1 = circular window mode, 0 = modulo 2^ADDR_WIDTH
- AGU_burst_start  in  1  start burst (idle only)
- AGU_burst_len  in  LEN_WIDTH  burst beat count
- AGU_out  out  ADDR_WIDTH  current address, combinational from register
- AGU_busy  out  1  burst in progress
- AGU_done  out  1  one-cycle pulse after burst completes
- AGU_wrapped  out  1  one-cycle pulse after any wrap, carry or borrow

## Operation
- Reset values:
  - address 0; stride 1; lim_lo 0; lim_hi all ones.
  - State IDLE; count 0.
  - AGU_busy, AGU_done and AGU_wrapped all 0.
- Priority each edge:
  - 1. AGU_wr_en.
  - 2. Burst FSM activity.
  - 3. inc/dec.
- Load: address ← AGU_in.
  - In BURST this aborts the burst: state goes to IDLE, no done pulse.
  - A value outside the window is accepted.
- Step +: sum = address + zext(stride), computed at ADDR_WIDTH+1 bits.
  - Wrap mode: if sum > lim_hi, address ← lim_lo and wrapped pulses; else address ← sum.
  - Modulo mode: address ← sum truncated; wrapped pulses on carry-out.
- Step −: computed wide.
  - Wrap mode: if address < lim_lo + stride, address ← lim_hi and wrapped pulses.
  - Modulo mode: truncated difference; wrapped pulses on borrow.
- inc and dec asserted together: no change.
- Config writes (stride, limits):
  - Accepted only in IDLE; ignored while busy.
  - A limit write with lo > hi is ignored entirely.
- FSM IDLE:
  - burst_start with len ≠ 0: count ← len, go to BURST.
  - burst_start with len = 0: no state change; done pulses next cycle.
- FSM BURST:
  - Every edge: step +, count ← count − 1.
  - When count = 1 at the edge: go to IDLE and pulse done.
  - burst_start, inc and dec are ignored.
  - Wrap mode applies to burst steps.

## Timing
- AGU_out reflects the address register with zero combinational delay. A load is visible in the cycle after the write edge.
- Burst of N with start address A:
  - AGU_busy is high for exactly N cycles, starting the cycle after the start edge.
  - AGU_out = A + k·stride during busy cycle k (k = 0…N−1).
  - The cycle after the last busy cycle: AGU_out = A + N·stride, AGU_done = 1, AGU_busy = 0.
- A new burst_start is accepted in the same cycle done is high (back-to-back, one idle cycle minimum).
- AGU_wrapped is registered. It is high in the cycle where AGU_out first shows the wrapped value.
- AGU_rst_n low at any time, including mid-burst: all state and outputs go to reset values immediately, with no clock needed. Release is synchronous to the next edge.

## Test plan
- Reset/load: assert rst_n=0 mid-burst → out=0, busy=0 asynchronously. Then load 0x1234 → out=0x1234 on the next cycle.
- Modulo step: address 0xFFFF, stride 1, inc → out=0x0000, wrapped=1 for one cycle. Then dec → 0xFFFF with wrapped pulse.
- Window wrap: lo=0x0100, hi=0x010F, stride 4, address 0x010C, wrap_en=1.
  - inc → 0x0100, wrapped=1.
  - dec → 0x010F.
  - Limit write lo=0x20, hi=0x10 → ignored.
- Burst: address 0x0100, stride 2, len 4 → busy for 4 cycles with out 0x0100, 0x0102, 0x0104, 0x0106; then out=0x0108, done=1.
- Abort/edge cases:
  - wr_en=0x0500 on the 2nd burst cycle → IDLE, out=0x0500, no done.
  - len=0 → done pulse, busy stays 0.
  - inc+dec together → unchanged.
  - stride write while busy → ignored.
